mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: memory-bus address width, with bit 8 as the I/O select.
REQ-002 Parameter DATA_W, default 16: bus data width.
REQ-003 Parameter BURST_MAX, default 4, legal range 1-15: maximum consecutive grants to one master while the other master is requesting.
REQ-004 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low reset (reset=0 resets).
REQ-006 Port m0_cmd  in  2: master 0 (CPU) command; 00 none, 01 read, 10 write, 11 treated as none.
REQ-007 Port m0_addr  in  ADDR_W: master 0 address.
REQ-008 Port m0_wdata  in  DATA_W: master 0 write data.
REQ-009 Port m0_gnt  out  1: master 0 access issued this cycle.
REQ-010 Port m0_rdata  out  DATA_W: master 0 read data.
REQ-011 Port m0_rvalid  out  1: m0_rdata valid this cycle.
REQ-012 Ports m1_cmd, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: identical to m0 for master 1 (loader/DMA).
REQ-013 Port mem_cmd  out  2: command to the RAM/I/O decode.
REQ-014 Port mem_addr  out  ADDR_W: address to the RAM/I/O decode.
REQ-015 Port mem_wdata  out  DATA_W: write data to the RAM/I/O decode.
REQ-016 Port mem_rdata  in  DATA_W: read data from RAM/I/O, valid one cycle after the read is issued.

Function
REQ-017 A master is requesting when its cmd is 01 or 10; it shall hold cmd, addr and wdata stable until the cycle its gnt is high.
REQ-018 Grant is combinational within the cycle: at most one gnt high per cycle; gnt is never high for a non-requesting master.
REQ-019 Only one master requesting -> that master granted.
REQ-020 Both requesting -> the master not granted last wins (round-robin), except as REQ-021 allows.
REQ-021 Burst exception: the last-granted master wins again while its consecutive-grant count is below BURST_MAX.
REQ-022 Count resets to 1 on a grant to a different master, increments (saturating at 15) on a repeat grant, and is unchanged in cycles with no grant.
REQ-023 In a grant cycle, mem_cmd/mem_addr/mem_wdata equal the granted master's values.
REQ-024 With no grant, mem_cmd = 00; mem_addr and mem_wdata hold their last granted values (no spurious toggling).
REQ-025 Granted read: the owner id is registered, and the next cycle asserts that master's rvalid for exactly 1 cycle with rdata = mem_rdata.
REQ-026 Read return is one cycle after grant, and a new grant may be issued in the same return cycle (full throughput, one access per cycle).
REQ-027 Granted write: no rvalid is generated.
REQ-028 Non-owner rdata is 0 whenever its rvalid is low; both rdata buses are 0 when no read is returning.
REQ-029 Writes shall not be reordered against reads: accesses reach mem_* in grant order.
REQ-030 The last-granted pointer updates only on a grant.

Reset
REQ-031 While reset=0, asynchronously: m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, rdata=0, mem_cmd=00, mem_addr=0, mem_wdata=0.
REQ-032 While reset=0, asynchronously: last-granted=master 1 (so master 0 wins the first tie), burst count=0, pending-read flag cleared.
REQ-033 A read granted in the cycle before reset assertion produces no rvalid after reset release.
REQ-034 The first grant is possible in the first clk edge cycle after reset deasserts.

Verification
REQ-035 Scenario: m0 read only, addr 0x005, RAM word 0xBEEF -> m0_gnt=1, mem_cmd=01, mem_addr=0x005; next cycle m0_rvalid=1, m0_rdata=0xBEEF, m1_rvalid=0.
REQ-036 Scenario: both masters issue continuous writes, BURST_MAX=4, starting after reset -> grant order m0,m1,m0,m1...; no burst forms because each tie alternates.
REQ-037 Scenario: m0 streams writes alone for 6 cycles, m1 begins requesting at cycle 2 -> m0 granted cycles 0-3 (count reaches 4), m1 granted cycle 4, m0 cycle 5.
REQ-038 Scenario: m1 write 0x00AA to 0x100 (LED I/O) then m0 read 0x140 (switches=0x3C) -> mem_cmd 10 then 01; m0_rdata=0x003C one cycle after its grant.
REQ-039 Scenario: m0 read granted, reset pulsed low before next edge -> no rvalid after release; all outputs 0 during reset.
REQ-040 Scenario: m0_cmd=11 with m1 idle -> no gnt, mem_cmd=00, no rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter onto a single-cycle RAM/I-O bus.
// Round-robin on contention, with a bounded burst allowance for a master
// that was already streaming when the other master started requesting.
// Reads return one cycle after their grant, routed to the issuing master.
module mem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {MST0 = 1'b0, MST1 = 1'b1} mst_e;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [3:0] BMAX     = 4'(BURST_MAX);
    localparam logic [3:0] CNT_SAT  = 4'd15;

    mst_e              last_q, owner_q, win;
    logic [3:0]        cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req0, req1, tie, keep, any_gnt;
    logic [1:0]        gcmd;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] gwdata;

    // Request decode and winner selection; reset masks every grant.
    // A run that began by winning a tie is a round-robin turn, so only a
    // run that was already going before contention may extend as a burst.
    always_comb begin
        req0 = (m0_cmd == CMD_RD) || (m0_cmd == CMD_WR);
        req1 = (m1_cmd == CMD_RD) || (m1_cmd == CMD_WR);
        tie  = req0 && req1;
        keep = run_q && (cnt_q < BMAX);
        if (tie)
            win = keep ? last_q : ((last_q == MST0) ? MST1 : MST0);
        else if (req1)
            win = MST1;
        else
            win = MST0;
        any_gnt = reset && (req0 || req1);
        m0_gnt  = any_gnt && (win == MST0);
        m1_gnt  = any_gnt && (win == MST1);
    end

    // Route the winner onto the bus; idle cycles hold the last address/data.
    always_comb begin
        gcmd      = (win == MST1) ? m1_cmd   : m0_cmd;
        gaddr     = (win == MST1) ? m1_addr  : m0_addr;
        gwdata    = (win == MST1) ? m1_wdata : m0_wdata;
        mem_cmd   = any_gnt ? gcmd   : CMD_NONE;
        mem_addr  = any_gnt ? gaddr  : addr_q;
        mem_wdata = any_gnt ? gwdata : wdata_q;
    end

    // Next-state for the consecutive-grant count, burst flag and read pending.
    always_comb begin
        if (win == last_q)
            cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 4'd1;
        else
            cnt_d = 4'd1;
        run_d  = !tie || keep;
        pend_d = any_gnt && (gcmd == CMD_RD);
    end

    // Arbitration history, bus hold registers and read-return owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= MST1;
            owner_q <= MST0;
            cnt_q   <= 4'd0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (any_gnt) begin
                last_q  <= win;
                owner_q <= win;
                cnt_q   <= cnt_d;
                run_q   <= run_d;
                addr_q  <= gaddr;
                wdata_q <= gwdata;
            end
        end
    end

    // Read return: only the owner sees data, everyone else sees zero.
    always_comb begin
        m0_rvalid = pend_q && (owner_q == MST0);
        m1_rvalid = pend_q && (owner_q == MST1);
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a grant-history reference model.
module tb_mem_arbiter;

    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m0_cmd, m1_cmd;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic [15:0] mem_rdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata, mem_wdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;

    mem_arbiter #(.ADDR_W(9), .DATA_W(16), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int who; bit rr;} g_t;
    g_t          hist[$];
    logic [15:0] ram [0:511];
    int          exp_rv_who = -1;
    logic [15:0] exp_rv_data = '0;
    logic [8:0]  exp_addr = '0;
    logic [15:0] exp_wd = '0;
    int          last_pick = -1;
    bit          rd_flag_n = 1'b0;
    logic [15:0] rd_data_n = '0;

    function automatic bit is_req(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    function automatic int last_who();
        return (hist.size() == 0) ? 1 : hist[$].who;
    endfunction

    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].who == hist[$].who) n++;
            else break;
        end
        return n;
    endfunction

    // Who gets the bus this cycle, from the rules: single requester wins;
    // ties go to the other master unless the last owner is mid-burst.
    function automatic int pick();
        bit r0 = is_req(m0_cmd);
        bit r1 = is_req(m1_cmd);
        if (reset !== 1'b1) return -1;
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (hist.size() != 0 && !hist[$].rr && run_len() < BMAX) return last_who();
        return 1 - last_who();
    endfunction

    // Compare mid-cycle, then commit what the coming edge does.
    int          cp;
    logic [1:0]  e_cmd;
    logic [8:0]  e_addr;
    logic [15:0] e_wd;
    bit          e_rv0, e_rv1;
    initial forever begin
        @(negedge clk);
        cp = pick();
        e_cmd  = (cp == 0) ? m0_cmd : (cp == 1) ? m1_cmd : 2'b00;
        e_addr = (cp == 0) ? m0_addr : (cp == 1) ? m1_addr : ((reset === 1'b1) ? exp_addr : 9'd0);
        e_wd   = (cp == 0) ? m0_wdata : (cp == 1) ? m1_wdata : ((reset === 1'b1) ? exp_wd : 16'd0);
        e_rv0  = (reset === 1'b1) && (exp_rv_who == 0);
        e_rv1  = (reset === 1'b1) && (exp_rv_who == 1);
        chk("gnt", {m1_gnt, m0_gnt}, {(cp == 1), (cp == 0)});
        chk("mem_cmd", mem_cmd, e_cmd);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rvalid", {m1_rvalid, m0_rvalid}, {e_rv1, e_rv0});
        chk("m0_rdata", m0_rdata, e_rv0 ? exp_rv_data : 16'd0);
        chk("m1_rdata", m1_rdata, e_rv1 ? exp_rv_data : 16'd0);

        rd_flag_n  = 1'b0;
        exp_rv_who = -1;
        if (reset !== 1'b1) begin
            hist.delete();
            exp_addr  = '0;
            exp_wd    = '0;
            last_pick = -1;
        end else begin
            last_pick = cp;
            if (cp >= 0) begin
                g_t e;
                e.who = cp;
                e.rr  = is_req(m0_cmd) && is_req(m1_cmd) && (cp != last_who());
                hist.push_back(e);
                if (hist.size() > 40) void'(hist.pop_front());
                if (e_cmd == 2'b01) begin
                    exp_rv_who  = cp;
                    exp_rv_data = ram[e_addr];
                    rd_flag_n   = 1'b1;
                    rd_data_n   = ram[e_addr];
                end else begin
                    ram[e_addr] = e_wd;
                end
                exp_addr = e_addr;
                exp_wd   = e_wd;
            end
        end
    end

    // Memory responder: read data one cycle after issue, junk otherwise.
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            mem_rdata = rd_flag_n ? rd_data_n : 16'($urandom);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cmd(output logic [1:0] c, output logic [8:0] a, output logic [15:0] d);
        int r = $urandom_range(0, 9);
        c = (r <= 3) ? 2'b10 : (r <= 6) ? 2'b01 : (r == 7) ? 2'b11 : 2'b00;
        a = 9'($urandom_range(0, 511));
        d = 16'($urandom);
    endtask

    logic [1:0] b_exp [6];

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'($urandom);
        ram[9'h005] = 16'hBEEF;
        ram[9'h140] = 16'h003C;
        reset = 1'b0;
        m0_cmd = 2'b00; m0_addr = '0; m0_wdata = '0;
        m1_cmd = 2'b00; m1_addr = '0; m1_wdata = '0;

        // Reset holds everything at zero even with a live request.
        step();
        m0_cmd = 2'b01; m0_addr = 9'h005;
        #1;
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_cmd", mem_cmd, 2'b00);
        chk("rst_addr", mem_addr, 9'h000);
        chk("rst_rv", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 32'h0);

        // Single read, first cycle after release.
        step();
        reset = 1'b1;
        #1;
        chk("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("rd_cmd", mem_cmd, 2'b01);
        chk("rd_addr", mem_addr, 9'h005);
        step();
        m0_cmd = 2'b11;
        #1;
        chk("rd_rv", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("rd_data", m0_rdata, 16'hBEEF);
        chk("rd_gnt11", {m1_gnt, m0_gnt}, 2'b00);
        chk("rd_cmd11", mem_cmd, 2'b00);
        chk("hold_addr", mem_addr, 9'h005);
        step();
        m0_cmd = 2'b00;
        #1;
        chk("cmd11_rv", {m1_rvalid, m0_rvalid}, 2'b00);

        // I/O write by m1 then switch read by m0.
        step();
        m1_cmd = 2'b10; m1_addr = 9'h100; m1_wdata = 16'h00AA;
        #1;
        chk("io_wgnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("io_wcmd", mem_cmd, 2'b10);
        chk("io_wdata", mem_wdata, 16'h00AA);
        step();
        m1_cmd = 2'b00; m0_cmd = 2'b01; m0_addr = 9'h140;
        #1;
        chk("io_rcmd", mem_cmd, 2'b01);
        chk("io_waddr", mem_addr, 9'h140);
        chk("io_wrv", {m1_rvalid, m0_rvalid}, 2'b00);
        step();
        m0_cmd = 2'b00;
        #1;
        chk("io_rdata", m0_rdata, 16'h003C);

        // Read granted, then reset in the return cycle: no rvalid survives.
        step();
        m0_cmd = 2'b01; m0_addr = 9'h140;
        #1;
        chk("rr_gnt", {m1_gnt, m0_gnt}, 2'b01);
        step();
        m0_cmd = 2'b00; reset = 1'b0;
        #1;
        chk("rr_rv", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rr_out0", {mem_cmd, mem_addr, mem_wdata, m0_rdata}, 32'h0);
        step();
        reset = 1'b1;
        #1;
        chk("rr_rv_rel", {m1_rvalid, m0_rvalid}, 2'b00);

        // Both stream writes after reset: strict alternation.
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        m0_cmd = 2'b10; m1_cmd = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt_gnt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            m0_addr = 9'($urandom_range(0, 511)); m1_addr = 9'($urandom_range(0, 511));
        end

        // m0 streams alone, m1 joins at cycle 2: burst up to BMAX then handover.
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        b_exp[0] = 2'b01; b_exp[1] = 2'b01; b_exp[2] = 2'b01;
        b_exp[3] = 2'b01; b_exp[4] = 2'b10; b_exp[5] = 2'b01;
        for (int c = 0; c < 6; c++) begin
            m0_cmd = 2'b10;
            m1_cmd = (c >= 2 && c <= 4) ? 2'b10 : 2'b00;
            #1;
            chk("burst_gnt", {m1_gnt, m0_gnt}, b_exp[c]);
            step();
        end
        m0_cmd = 2'b00; m1_cmd = 2'b00;

        // Random traffic; requests are held until the model says granted.
        for (int n = 0; n < 3000; n++) begin
            step();
            if (reset == 1'b0) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            if (last_pick == 0 || !is_req(m0_cmd)) new_cmd(m0_cmd, m0_addr, m0_wdata);
            if (last_pick == 1 || !is_req(m1_cmd)) new_cmd(m1_cmd, m1_addr, m1_wdata);
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
